// File: rtl/vigna_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply (MUL_STEP bits/cycle), restoring divide.
// Optional VIGNA_MULDIV_EARLY_OUT_EN: multiply finishes once the remaining multiplier magnitude is zero.
module vigna_muldiv #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int MUL_CYC = XLEN / MUL_STEP;
    localparam int CW      = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t              state;
    logic [2:0]          fn;
    logic                neg_a_q, neg_b_q;
    logic [CW-1:0]       cnt;
    logic [2*XLEN-1:0]   prod, mcand;
    logic [XLEN-1:0]     mplier;
    logic [XLEN-1:0]     rem_q, quo, dvs;

    // Request decode on the raw inputs (only meaningful in IDLE)
    logic            in_mul, sign_a, sign_b, na, nb;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] spec_res;

    always_comb begin
        in_mul   = !funct3[2];
        sign_a   = in_mul ? (funct3 != 3'd3) : !funct3[0];
        sign_b   = in_mul ? !funct3[1] : !funct3[0];
        na       = sign_a & op_a[XLEN-1];
        nb       = sign_b & op_b[XLEN-1];
        mag_a    = na ? -op_a : op_a;
        mag_b    = nb ? -op_b : op_b;
        div_zero = (op_b == '0);
        div_ovf  = !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
        special  = funct3[2] && (div_zero || div_ovf);
        if (div_zero)
            spec_res = funct3[1] ? op_a : '1;
        else
            spec_res = funct3[1] ? '0 : op_a;
    end

    // The accept edge already performs the first iteration step, so the
    // step datapath reads fresh operands in IDLE and registers otherwise.
    logic              idle;
    logic [CW-1:0]     step_cnt, cnt_nx;
    logic [2*XLEN-1:0] m_acc_in, m_cand_in, m_acc_nx, m_cand_nx;
    logic [XLEN-1:0]   m_plr_in, m_plr_nx;
    logic              mul_last;

    always_comb begin
        idle      = (state == S_IDLE);
        step_cnt  = idle ? '0 : cnt;
        cnt_nx    = step_cnt + CW'(1);
        m_acc_in  = idle ? '0 : prod;
        m_cand_in = idle ? {{XLEN{1'b0}}, mag_a} : mcand;
        m_plr_in  = idle ? mag_b : mplier;
        m_acc_nx  = m_acc_in;
        for (int i = 0; i < MUL_STEP; i++)
            if (m_plr_in[i]) m_acc_nx = m_acc_nx + (m_cand_in << i);
        m_cand_nx = m_cand_in << MUL_STEP;
        m_plr_nx  = m_plr_in >> MUL_STEP;
`ifdef VIGNA_MULDIV_EARLY_OUT_EN
        mul_last  = (m_plr_nx == '0) || (step_cnt == CW'(MUL_CYC - 1));
`else
        mul_last  = (step_cnt == CW'(MUL_CYC - 1));
`endif
    end

    logic [XLEN-1:0] d_rem_in, d_quo_in, d_dvs_in, d_rem_nx, d_quo_nx;
    logic [XLEN:0]   d_shift, d_trial;
    logic            div_last;

    always_comb begin
        d_rem_in = idle ? '0 : rem_q;
        d_quo_in = idle ? mag_a : quo;
        d_dvs_in = idle ? mag_b : dvs;
        d_shift  = {d_rem_in, d_quo_in[XLEN-1]};
        d_trial  = d_shift - {1'b0, d_dvs_in};
        if (!d_trial[XLEN]) begin
            d_rem_nx = d_trial[XLEN-1:0];
            d_quo_nx = {d_quo_in[XLEN-2:0], 1'b1};
        end else begin
            d_rem_nx = d_shift[XLEN-1:0];
            d_quo_nx = {d_quo_in[XLEN-2:0], 1'b0};
        end
        div_last = (step_cnt == CW'(XLEN - 1));
    end

    // Sign fix-up and result select
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix, fix_res;

    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
        q_fix    = (neg_a_q ^ neg_b_q) ? -quo : quo;
        r_fix    = neg_a_q ? -rem_q : rem_q;
        if (!fn[2])
            fix_res = (fn[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else
            fix_res = fn[1] ? r_fix : q_fix;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            fn        <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            cnt       <= '0;
            prod      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem_q     <= '0;
            quo       <= '0;
            dvs       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        fn       <= funct3;
                        neg_a_q  <= na;
                        neg_b_q  <= nb;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= cnt_nx;
                        if (in_mul) begin
                            prod   <= m_acc_nx;
                            mcand  <= m_cand_nx;
                            mplier <= m_plr_nx;
                            state  <= mul_last ? S_FIX : S_MUL;
                        end else if (special) begin
                            result    <= spec_res;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            rem_q <= d_rem_nx;
                            quo   <= d_quo_nx;
                            dvs   <= d_dvs_in;
                            state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    prod   <= m_acc_nx;
                    mcand  <= m_cand_nx;
                    mplier <= m_plr_nx;
                    cnt    <= cnt_nx;
                    if (mul_last) state <= S_FIX;
                end
                S_DIV: begin
                    rem_q <= d_rem_nx;
                    quo   <= d_quo_nx;
                    cnt   <= cnt_nx;
                    if (div_last) state <= S_FIX;
                end
                S_FIX: begin
                    result    <= fix_res;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
